// File: rtl/parity_frame_tx_if.sv
// Handshake and serial-line bundle for parity_frame_tx.
// The err_inj signal exists only when PAR_ERR_INJECT_EN is defined.
interface parity_frame_tx_if #(
    parameter int unsigned DATA_W = 4
);
    logic [DATA_W-1:0] data_in;
    logic              par_odd;
    logic              valid;
    logic              ready;
    logic              tx;
    logic              even_par;
    logic              odd_par;
    logic              busy;
    logic              done;
`ifdef PAR_ERR_INJECT_EN
    logic              err_inj;
`endif

    modport master (
        output data_in, par_odd, valid,
`ifdef PAR_ERR_INJECT_EN
        output err_inj,
`endif
        input  ready, tx, even_par, odd_par, busy, done
    );

    modport slave (
        input  data_in, par_odd, valid,
`ifdef PAR_ERR_INJECT_EN
        input  err_inj,
`endif
        output ready, tx, even_par, odd_par, busy, done
    );
endinterface

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W bits LSB first, parity bit, stop bit.
// Define PAR_ERR_INJECT_EN to add err_inj, which corrupts the sent parity bit of one frame.
module parity_frame_tx #(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    parity_frame_tx_if.slave    bus
);
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_odd_q, par_odd_d;
    logic              even_par_q, even_par_d;
    logic              inj_q, inj_d;
    logic              done_q, done_d;
    logic              tx_val;
    logic              bit_end;
    logic              par_bit;
    logic              inj_in;

`ifdef PAR_ERR_INJECT_EN
    assign inj_in = bus.err_inj;
`else
    assign inj_in = 1'b0;
`endif

    assign bit_end = (cnt_q == CntW'(CLKS_PER_BIT - 1));
    // inj_q is constant zero unless error injection is built in
    assign par_bit = (par_odd_q ? ~even_par_q : even_par_q) ^ inj_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            par_odd_q  <= 1'b0;
            even_par_q <= 1'b0;
            inj_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            par_odd_q  <= par_odd_d;
            even_par_q <= even_par_d;
            inj_q      <= inj_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        par_odd_d  = par_odd_q;
        even_par_d = even_par_q;
        inj_d      = inj_q;
        done_d     = 1'b0;
        tx_val     = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (bus.valid) begin
                    data_d     = bus.data_in;
                    par_odd_d  = bus.par_odd;
                    even_par_d = ^bus.data_in;
                    inj_d      = inj_in;
                    cnt_d      = '0;
                    idx_d      = '0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                tx_val = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                tx_val = data_q[idx_q];
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IdxW'(DATA_W - 1)) begin
                        idx_d   = '0;
                        state_d = StParity;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StParity: begin
                tx_val = par_bit;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                tx_val = 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.ready    = (state_q == StIdle);
    assign bus.busy     = (state_q != StIdle);
    assign bus.tx       = tx_val;
    assign bus.even_par = even_par_q;
    assign bus.odd_par  = ~even_par_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: directed vector table, reset and
// back-to-back sequences, and random frames checked against a bit-list model.
module tb_parity_frame_tx;
    localparam int DW    = 4;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 3) * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    parity_frame_tx_if #(.DATA_W(DW)) bus ();

    parity_frame_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] data;
        logic       po;
        logic       inj;
        logic       hold;
        logic [3:0] mid;
        int         exp_par;
        logic       exp_even;
        string      tag;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_inj(input logic v);
`ifdef PAR_ERR_INJECT_EN
        bus.err_inj = v;
`else
        bus.par_odd = bus.par_odd ^ (v & 1'b0);
`endif
    endtask

    // Offers one word, then checks every cycle of the frame against a list of
    // line levels built from the frame rules; ends in the done cycle.
    task automatic run_frame(input logic [3:0] d, input logic po, input logic inj,
                             input logic hold, input logic [3:0] mid, input int exp_par,
                             input string tag);
        logic exp_tx[$];
        logic eff_inj;
        logic bits[$];
        int   n;
`ifdef PAR_ERR_INJECT_EN
        eff_inj = inj;
`else
        eff_inj = 1'b0;
`endif
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: ready timeout, got %b expected 1", tag, bus.ready);
            return;
        end
        bus.valid   = 1'b1;
        bus.data_in = d;
        bus.par_odd = po;
        set_inj(inj);

        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        bits.push_back((^d) ^ po ^ eff_inj);
        bits.push_back(1'b1);
        foreach (bits[b]) for (int c = 0; c < CPB; c++) exp_tx.push_back(bits[b]);

        @(posedge clk);
        #1;
        if (!hold) bus.valid = 1'b0;
        bus.data_in = mid;
        bus.par_odd = ~po;
        set_inj(~inj);
        chk({tag, " even_par"}, 32'(bus.even_par), 32'(^d));
        chk({tag, " odd_par"}, 32'(bus.odd_par), 32'(~^d));
        for (int k = 0; k < FRAME; k++) begin
            chk($sformatf("%s tx[%0d]", tag, k), 32'(bus.tx), 32'(exp_tx[k]));
            chk($sformatf("%s busy[%0d]", tag, k), 32'(bus.busy), 32'd1);
            chk($sformatf("%s ready[%0d]", tag, k), 32'(bus.ready), 32'd0);
            chk($sformatf("%s done[%0d]", tag, k), 32'(bus.done), 32'd0);
            if (k == (DW + 1) * CPB && exp_par >= 0)
                chk({tag, " parity bit"}, 32'(bus.tx), 32'(exp_par));
            @(posedge clk);
            #1;
        end
        chk({tag, " done pulse"}, 32'(bus.done), 32'd1);
        chk({tag, " idle tx"}, 32'(bus.tx), 32'd1);
        chk({tag, " idle ready"}, 32'(bus.ready), 32'd1);
        chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " even_par held"}, 32'(bus.even_par), 32'(^d));
    endtask

    initial begin
        vecs[0] = '{4'b1011, 1'b0, 1'b0, 1'b0, 4'b1111, 1, 1'b1, "w1011_even"};
        vecs[1] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b1111, 1, 1'b0, "w0000_odd"};
        vecs[2] = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0, "w1111_even"};
        vecs[3] = '{4'b0101, 1'b0, 1'b0, 1'b1, 4'b1111, 0, 1'b0, "b2b_first"};
        vecs[4] = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'b1111, 1, 1'b1, "b2b_second"};

        bus.valid   = 1'b0;
        bus.data_in = '0;
        bus.par_odd = 1'b0;
        set_inj(1'b0);

        #1;
        chk("rst tx", 32'(bus.tx), 32'd1);
        chk("rst ready", 32'(bus.ready), 32'd1);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst even_par", 32'(bus.even_par), 32'd0);
        chk("rst odd_par", 32'(bus.odd_par), 32'd1);
        #21;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Rows 3 and 4 run with no gap: valid stays high into the done cycle.
        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].data, vecs[v].po, vecs[v].inj, vecs[v].hold, vecs[v].mid,
                      vecs[v].exp_par, vecs[v].tag);
            chk({vecs[v].tag, " even_par table"}, 32'(bus.even_par), 32'(vecs[v].exp_even));
        end
        bus.valid = 1'b0;
        @(posedge clk);
        #1;

`ifdef PAR_ERR_INJECT_EN
        run_frame(4'b1011, 1'b0, 1'b1, 1'b0, 4'b0000, 0, "inject");
        chk("inject even_par", 32'(bus.even_par), 32'd1);
        set_inj(1'b0);
        run_frame(4'b1011, 1'b0, 1'b0, 1'b0, 4'b0000, 1, "after_inject");
`endif

        // Abort a frame from inside the data bits.
        bus.valid   = 1'b1;
        bus.data_in = 4'b0111;
        bus.par_odd = 1'b0;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        repeat (CPB + 2) begin
            @(posedge clk);
            #1;
        end
        chk("pre-abort busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort tx", 32'(bus.tx), 32'd1);
        chk("abort ready", 32'(bus.ready), 32'd1);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort even_par", 32'(bus.even_par), 32'd0);
        chk("abort odd_par", 32'(bus.odd_par), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort no done", 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        run_frame(4'b0110, 1'b1, 1'b0, 1'b0, 4'b1001, 1, "post_reset");
        bus.valid = 1'b0;

        for (int r = 0; r < 25; r++) begin
            logic [3:0] d;
            logic       po;
            logic       inj;
            logic       hold;
            d    = 4'($urandom_range(0, 15));
            po   = 1'($urandom_range(0, 1));
            inj  = 1'($urandom_range(0, 1));
            hold = (r == 24) ? 1'b0 : 1'($urandom_range(0, 1));
            run_frame(d, po, inj, hold, 4'($urandom_range(0, 15)), -1, $sformatf("rnd%0d", r));
            if (!hold) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                    chk("rnd gap tx", 32'(bus.tx), 32'd1);
                end
            end
        end
        bus.valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
